// File: rtl/caxi4dma_rd_burst_engine.sv
// caxi4dma_rd_burst_engine: splits one read descriptor into AXI4 read bursts,
// honouring priority caps, 4 KB boundaries and an outstanding-burst limit.
// Ports: desc_* (descriptor in, valid/ready), rd_req_* (burst request out,
// valid/ready), rd_cmpl_* (burst completion in), done/done_err (finish pulse),
// busy (not idle), outstanding (bursts in flight). All outputs registered.
module caxi4dma_rd_burst_engine #(
  parameter int ADDR_WIDTH      = 32,
  parameter int BYTE_CNT_WIDTH  = 23,
  parameter int DATA_BYTES      = 8,
  parameter int NUM_PRI_LVLS    = 4,
  parameter int MAX_BURST_LEN   = 256,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic                      desc_valid,
  output logic                      desc_ready,
  input  logic [ADDR_WIDTH-1:0]     desc_addr,
  input  logic [BYTE_CNT_WIDTH-1:0] desc_byte_cnt,
  input  logic [NUM_PRI_LVLS-1:0]   desc_pri,
  input  logic                      desc_fixed,
  output logic                      rd_req_valid,
  input  logic                      rd_req_ready,
  output logic [ADDR_WIDTH-1:0]     rd_req_addr,
  output logic [7:0]                rd_req_len,
  output logic [1:0]                rd_req_burst,
  input  logic                      rd_cmpl_valid,
  input  logic                      rd_cmpl_err,
  output logic                      done,
  output logic                      done_err,
  output logic                      busy,
  output logic [3:0]                outstanding
);

  localparam int AW = ADDR_WIDTH;
  localparam int RW = BYTE_CNT_WIDTH;
  localparam int SH = $clog2(DATA_BYTES);

  typedef enum logic [2:0] {
    S_IDLE, S_CALC, S_ISSUE, S_DRAIN, S_FINISH
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [RW-1:0]   rem_q, rem_d;
  logic [8:0]      cap_q, cap_d;
  logic            fixed_q, fixed_d;
  logic            err_q, err_d;

  logic            desc_ready_d, req_valid_d;
  logic [AW-1:0]   req_addr_d;
  logic [7:0]      req_len_d;
  logic [1:0]      req_burst_d;
  logic            done_d, done_err_d, busy_d;
  logic [3:0]      out_d;

  logic [8:0]      pri_cap;
  logic [RW:0]     cnt_sum;
  logic [RW-1:0]   beats_total;
  logic [12:0]     span, blk;
  logic [8:0]      lim, lim_c, beats, req_beats;
  logic            hs, cmpl_ok;

  // Zero or multi-hot priority falls back to the lowest level.
  always_comb begin : pri_dec
    int lvl;
    int c;
    lvl = NUM_PRI_LVLS - 1;
    if ($onehot(desc_pri)) begin
      for (int i = 0; i < NUM_PRI_LVLS; i++)
        if (desc_pri[i]) lvl = i;
    end
    c = MAX_BURST_LEN >> lvl;
    if (c < 1) c = 1;
    if (c > 256) c = 256;
    pri_cap = 9'(c);
  end

  assign cnt_sum = {1'b0, desc_byte_cnt} + (RW+1)'(DATA_BYTES - 1);
  assign beats_total = RW'(cnt_sum >> SH);

  // Beats left before the next 4 KB page; FIXED never crosses.
  assign span  = 13'd4096 - {1'b0, addr_q[11:0]};
  assign blk   = span >> SH;
  assign lim   = (fixed_q || blk > 13'd256) ? 9'd256 : blk[8:0];
  assign lim_c = (cap_q < lim) ? cap_q : lim;
  assign beats = (rem_q < RW'(lim_c)) ? rem_q[8:0] : lim_c;

  assign req_beats = {1'b0, rd_req_len} + 9'd1;
  assign hs = (state_q == S_ISSUE) && rd_req_valid && rd_req_ready;
  assign cmpl_ok = rd_cmpl_valid && (outstanding != 4'd0);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    cap_d       = cap_q;
    fixed_d     = fixed_q;
    err_d       = err_q;
    req_valid_d = rd_req_valid;
    req_addr_d  = rd_req_addr;
    req_len_d   = rd_req_len;
    req_burst_d = rd_req_burst;
    done_d      = 1'b0;
    done_err_d  = 1'b0;
    out_d       = outstanding + 4'(hs) - 4'(cmpl_ok);
    if (cmpl_ok && rd_cmpl_err) err_d = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (desc_valid && desc_ready) begin
          addr_d  = desc_addr;
          rem_d   = beats_total;
          cap_d   = pri_cap;
          fixed_d = desc_fixed;
          state_d = (beats_total == '0) ? S_FINISH : S_CALC;
        end
      end
      S_CALC: begin
        if (err_q) begin
          state_d = S_DRAIN;
        end else if (outstanding < 4'(MAX_OUTSTANDING)) begin
          req_valid_d = 1'b1;
          req_addr_d  = addr_q;
          req_len_d   = 8'(beats - 9'd1);
          req_burst_d = fixed_q ? 2'b00 : 2'b01;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (hs) begin
          req_valid_d = 1'b0;
          rem_d = rem_q - RW'(req_beats);
          if (!fixed_q) addr_d = addr_q + (AW'(req_beats) << SH);
          if (err_q || rem_q == RW'(req_beats)) state_d = S_DRAIN;
          else state_d = S_CALC;
        end
      end
      S_DRAIN: begin
        if (outstanding == 4'd0) state_d = S_FINISH;
      end
      S_FINISH: begin
        done_d     = 1'b1;
        done_err_d = err_q;
        err_d      = 1'b0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    desc_ready_d = (state_d == S_IDLE);
    busy_d       = (state_d != S_IDLE);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      rem_q        <= '0;
      cap_q        <= '0;
      fixed_q      <= 1'b0;
      err_q        <= 1'b0;
      desc_ready   <= 1'b1;
      rd_req_valid <= 1'b0;
      rd_req_addr  <= '0;
      rd_req_len   <= '0;
      rd_req_burst <= '0;
      done         <= 1'b0;
      done_err     <= 1'b0;
      busy         <= 1'b0;
      outstanding  <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      rem_q        <= rem_d;
      cap_q        <= cap_d;
      fixed_q      <= fixed_d;
      err_q        <= err_d;
      desc_ready   <= desc_ready_d;
      rd_req_valid <= req_valid_d;
      rd_req_addr  <= req_addr_d;
      rd_req_len   <= req_len_d;
      rd_req_burst <= req_burst_d;
      done         <= done_d;
      done_err     <= done_err_d;
      busy         <= busy_d;
      outstanding  <= out_d;
    end
  end

endmodule

// File: doc/caxi4dma_rd_burst_engine.md
Name: caxi4dma_rd_burst_engine

Overview:
- Next-generation read transaction controller for the AXI4 DMA controller.
- Takes one read descriptor: start address, byte count, priority and address mode. Splits it into AXI4 read bursts and issues them to the AXI master read-address channel.
- Keeps up to MAX_OUTSTANDING bursts in flight, applies per-priority burst caps and 4 KB boundary splitting, aborts cleanly on error.
- Sits between the descriptor fetch/arbiter stage and the AXI4 master read interface.

Parameters:
- ADDR_WIDTH, 32, address width.
- BYTE_CNT_WIDTH, 23, descriptor byte-count width.
- DATA_BYTES, 8, bus width in bytes (power of 2, 1..64).
- NUM_PRI_LVLS, 4, number of one-hot priority levels (1..8).
- MAX_BURST_LEN, 256, beats for priority 0. Priority p cap = max(1, MAX_BURST_LEN >> p).
- MAX_OUTSTANDING, 4, maximum bursts in flight (1..15).

Ports:
- CLOCK  in  1  clock
- RESETN  in  1  asynchronous active-low reset
- DESC_VALID  in  1  descriptor offered
- DESC_READY  out  1  engine accepts descriptor (IDLE only)
- DESC_ADDR  in  ADDR_WIDTH  start address, DATA_BYTES-aligned
- DESC_BYTE_CNT  in  BYTE_CNT_WIDTH  bytes to read
- DESC_PRI  in  NUM_PRI_LVLS  one-hot priority; zero or multi-hot treated as lowest level
- DESC_FIXED  in  1  1 = FIXED burst (same address every beat), 0 = INCR
- RD_REQ_VALID  out  1  burst request valid
- RD_REQ_READY  in  1  master accepts request
- RD_REQ_ADDR  out  ADDR_WIDTH  burst start address
- RD_REQ_LEN  out  8  beats minus 1
- RD_REQ_BURST  out  2  01 INCR, 00 FIXED
- RD_CMPL_VALID  in  1  one burst fully returned (last beat seen)
- RD_CMPL_ERR  in  1  that burst had SLVERR/DECERR
- DONE  out  1  one-cycle pulse, descriptor finished
- DONE_ERR  out  1  qualified by DONE, descriptor aborted on error
- BUSY  out  1  not in IDLE
- OUTSTANDING  out  4  bursts in flight

Behaviour:
- Reset values: state IDLE; DESC_READY=1; RD_REQ_VALID=0; RD_REQ_ADDR/LEN/BURST=0; DONE=0; DONE_ERR=0; BUSY=0; OUTSTANDING=0. All outputs are registered.
- Remaining beats at acceptance = ceil(DESC_BYTE_CNT / DATA_BYTES).
- States: IDLE, CALC, ISSUE, DRAIN, FINISH.
- IDLE:
  - DESC_VALID & DESC_READY latches the descriptor, goes to CALC, DESC_READY→0.
  - If byte count is 0: go directly to FINISH, no requests issued.
- CALC (1 cycle):
  - beats = min(remaining, priority cap, INCR ? (4096 − addr[11:0]) / DATA_BYTES : 256).
  - Load RD_REQ_* from that value.
  - If OUTSTANDING < MAX_OUTSTANDING, assert RD_REQ_VALID and go to ISSUE.
  - Otherwise stay in CALC until a completion frees a slot.
- ISSUE:
  - RD_REQ_* stay stable while VALID & !READY.
  - On handshake: RD_REQ_VALID drops; OUTSTANDING+1; remaining −= beats; address += beats*DATA_BYTES for INCR, unchanged for FIXED.
  - After handshake: remaining>0 → CALC, else → DRAIN.
  - Back-to-back bursts are therefore 2 cycles apart minimum.
- Completion, any state:
  - RD_CMPL_VALID decrements OUTSTANDING.
  - Issue handshake and completion in the same cycle leave OUTSTANDING unchanged.
  - A completion with OUTSTANDING=0 is ignored; the counter never wraps.
- Error:
  - RD_CMPL_ERR with RD_CMPL_VALID sets a sticky error flag.
  - In CALC, with the flag set, no new request is raised; go to DRAIN.
  - A request already valid in ISSUE completes its handshake (AXI forbids withdrawal), then goes to DRAIN.
- DRAIN: wait for OUTSTANDING==0, then FINISH.
- FINISH (1 cycle):
  - DONE=1, DONE_ERR=sticky flag.
  - Clear flag, return to IDLE, DESC_READY=1.
- RESETN low mid-operation: immediate return to reset values. In-flight bursts are forgotten; any later completions are discarded by the zero-floor rule.
- Address arithmetic is modulo 2^ADDR_WIDTH.

Test Plan:
- DATA_BYTES=8, priority 0, INCR, addr 0x1000, 4096 bytes, READY=1:
  - expect bursts (0x1000, LEN 255) then (0x1800, LEN 255);
  - after 2 completions, DONE=1, DONE_ERR=0.
- Addr 0x0FC0, 256 bytes, priority 0:
  - 4 KB split gives (0x0FC0, LEN 7) and (0x1000, LEN 23).
- Priority one-hot 0b0100 (cap 64), 2048 bytes, MAX_OUTSTANDING=2, completions withheld:
  - exactly 2 requests issued, stall in CALC, OUTSTANDING=2;
  - release one completion → third request issues.
- FIXED, addr 0x40, 24 bytes:
  - single request (0x40, LEN 2, BURST 00).
- 4 bursts outstanding, second completion carries RD_CMPL_ERR:
  - no new requests, DONE pulses after the last completion with DONE_ERR=1.
- Byte count 0 → DONE 2 cycles after acceptance, no RD_REQ_VALID.
- RESETN low during ISSUE → all outputs at reset values on the next cycle.
